// File: rtl/pspin_cluster_seq_if.sv
// Control/status bundle between the host-side register block and the
// cluster boot/run sequencer.
interface pspin_cluster_seq_if #(
   parameter int NUM_CLUSTERS = 2,
   parameter int CNT_WIDTH    = 32
);
   logic                    start_i;
   logic                    stop_i;
   logic [NUM_CLUSTERS-1:0] cl_mask_i;
   logic [CNT_WIDTH-1:0]    timeout_i;
   logic [NUM_CLUSTERS-1:0] cl_eoc_i;
   logic                    aux_rst_o;
   logic [NUM_CLUSTERS-1:0] cl_fetch_en_o;
   logic [2:0]              state_o;
   logic                    done_o;
   logic                    timeout_o;
   logic [NUM_CLUSTERS-1:0] eoc_seen_o;
   logic [CNT_WIDTH-1:0]    cycles_o;

   // Host / cluster side: issues requests, supplies end-of-computation.
   modport master (
      output start_i, stop_i, cl_mask_i, timeout_i, cl_eoc_i,
      input  aux_rst_o, cl_fetch_en_o, state_o, done_o, timeout_o,
             eoc_seen_o, cycles_o
   );

   // Sequencer side.
   modport slave (
      input  start_i, stop_i, cl_mask_i, timeout_i, cl_eoc_i,
      output aux_rst_o, cl_fetch_en_o, state_o, done_o, timeout_o,
             eoc_seen_o, cycles_o
   );
endinterface

// File: rtl/pspin_cluster_seq.sv
// Cluster boot/run sequencer: pulses the cluster reset, staggers fetch
// enables across the selected clusters, watches end-of-computation under a
// cycle budget and parks in DONE with status for the host.
module pspin_cluster_seq #(
   parameter int NUM_CLUSTERS   = 2,
   parameter int RST_CYCLES     = 16,
   parameter int STAGGER_CYCLES = 8,
   parameter int CNT_WIDTH      = 32
) (
   input logic                clk,
   input logic                rst,
   pspin_cluster_seq_if.slave bus
);

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      RESET  = 3'd1,
      ENABLE = 3'd2,
      RUN    = 3'd3,
      STOP   = 3'd4,
      DONE   = 3'd5
   } state_t;

   localparam logic [31:0] RST_LAST     = 32'(RST_CYCLES - 1);
   localparam logic [31:0] STAGGER_LAST = 32'(STAGGER_CYCLES - 1);

   state_t                  state_q, state_d;
   logic                    aux_rst_q, aux_rst_d;
   logic [NUM_CLUSTERS-1:0] fetch_q, fetch_d;
   logic                    done_q, done_d;
   logic                    timeout_q, timeout_d;
   logic [NUM_CLUSTERS-1:0] eoc_q, eoc_d;
   logic [CNT_WIDTH-1:0]    cycles_q, cycles_d;
   logic [NUM_CLUSTERS-1:0] mask_q, mask_d;
   logic [CNT_WIDTH-1:0]    tmo_q, tmo_d;
   logic [31:0]             cnt_q, cnt_d;

   logic [NUM_CLUSTERS-1:0] pending;
   logic [NUM_CLUSTERS-1:0] low_bit;
   logic                    last_bit;
   logic [NUM_CLUSTERS-1:0] eoc_acc;
   logic                    tmo_hit;
   logic [CNT_WIDTH-1:0]    cycles_inc;

   // Next-state and next-output decode; every register defaults to holding.
   always_comb begin
      state_d   = state_q;
      aux_rst_d = aux_rst_q;
      fetch_d   = fetch_q;
      done_d    = done_q;
      timeout_d = timeout_q;
      eoc_d     = eoc_q;
      cycles_d  = cycles_q;
      mask_d    = mask_q;
      tmo_d     = tmo_q;
      cnt_d     = cnt_q;

      pending    = mask_q & ~fetch_q;
      low_bit    = pending & (-pending);
      last_bit   = ((pending & ~low_bit) == '0);
      eoc_acc    = eoc_q | (bus.cl_eoc_i & mask_q);
      tmo_hit    = (tmo_q != '0) && (cycles_q == tmo_q);
      cycles_inc = (&cycles_q) ? cycles_q : cycles_q + CNT_WIDTH'(1);

      case (state_q)
         IDLE, DONE: begin
            if (bus.start_i && (bus.cl_mask_i != '0)) begin
               mask_d    = bus.cl_mask_i;
               tmo_d     = bus.timeout_i;
               timeout_d = 1'b0;
               eoc_d     = '0;
               cycles_d  = '0;
               fetch_d   = '0;
               done_d    = 1'b0;
               aux_rst_d = 1'b1;
               cnt_d     = '0;
               state_d   = RESET;
            end
         end

         RESET: begin
            if (bus.stop_i) begin
               state_d   = STOP;
               fetch_d   = '0;
               aux_rst_d = 1'b1;
               cnt_d     = '0;
            end else if (cnt_q == RST_LAST) begin
               aux_rst_d = 1'b0;
               fetch_d   = fetch_q | low_bit;
               cycles_d  = '0;
               cnt_d     = '0;
               state_d   = last_bit ? RUN : ENABLE;
            end else begin
               cnt_d = cnt_q + 32'd1;
            end
         end

         ENABLE: begin
            eoc_d    = eoc_acc;
            cycles_d = cycles_inc;
            if (tmo_hit || bus.stop_i) begin
               timeout_d = tmo_hit ? 1'b1 : timeout_q;
               state_d   = STOP;
               fetch_d   = '0;
               aux_rst_d = 1'b1;
               cnt_d     = '0;
            end else if (cnt_q == STAGGER_LAST) begin
               fetch_d = fetch_q | low_bit;
               cnt_d   = '0;
               if (last_bit) begin
                  state_d = RUN;
               end
            end else begin
               cnt_d = cnt_q + 32'd1;
            end
         end

         RUN: begin
            eoc_d    = eoc_acc;
            cycles_d = cycles_inc;
            if (eoc_acc == mask_q) begin
               state_d = DONE;
               fetch_d = '0;
               done_d  = 1'b1;
            end else if (tmo_hit || bus.stop_i) begin
               timeout_d = tmo_hit ? 1'b1 : timeout_q;
               state_d   = STOP;
               fetch_d   = '0;
               aux_rst_d = 1'b1;
               cnt_d     = '0;
            end
         end

         STOP: begin
            if (cnt_q == RST_LAST) begin
               aux_rst_d = 1'b0;
               done_d    = 1'b1;
               cnt_d     = '0;
               state_d   = DONE;
            end else begin
               cnt_d = cnt_q + 32'd1;
            end
         end

         default: begin
            state_d   = IDLE;
            aux_rst_d = 1'b0;
            fetch_d   = '0;
            done_d    = 1'b0;
            cnt_d     = '0;
         end
      endcase
   end

   // State and output registers; async reset removes cluster fetch at once.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= IDLE;
         aux_rst_q <= 1'b0;
         fetch_q   <= '0;
         done_q    <= 1'b0;
         timeout_q <= 1'b0;
         eoc_q     <= '0;
         cycles_q  <= '0;
         mask_q    <= '0;
         tmo_q     <= '0;
         cnt_q     <= '0;
      end else begin
         state_q   <= state_d;
         aux_rst_q <= aux_rst_d;
         fetch_q   <= fetch_d;
         done_q    <= done_d;
         timeout_q <= timeout_d;
         eoc_q     <= eoc_d;
         cycles_q  <= cycles_d;
         mask_q    <= mask_d;
         tmo_q     <= tmo_d;
         cnt_q     <= cnt_d;
      end
   end

   assign bus.aux_rst_o     = aux_rst_q;
   assign bus.cl_fetch_en_o = fetch_q;
   assign bus.state_o       = state_q;
   assign bus.done_o        = done_q;
   assign bus.timeout_o     = timeout_q;
   assign bus.eoc_seen_o    = eoc_q;
   assign bus.cycles_o      = cycles_q;

endmodule

// File: tb/tb_pspin_cluster_seq.sv
// Directed bench for the cluster sequencer: boot, sparse mask, timeout with
// concurrent stop, restart, abort, saturation and asynchronous reset.
module tb_pspin_cluster_seq;

   localparam int NC = 4;
   localparam int RC = 4;
   localparam int SC = 3;
   localparam int CW = 8;

   logic clk = 1'b0;
   logic rst;

   int assert_count = 0;
   int fail_count   = 0;
   int cyc          = 0;

   pspin_cluster_seq_if #(.NUM_CLUSTERS(NC), .CNT_WIDTH(CW)) bus ();

   pspin_cluster_seq #(
      .NUM_CLUSTERS   (NC),
      .RST_CYCLES     (RC),
      .STAGGER_CYCLES (SC),
      .CNT_WIDTH      (CW)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   // Free-running 10 ns clock.
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic go_to(input int n);
      while (cyc < n) step();
   endtask

   task automatic apply_stimulus(input logic st, input logic sp,
                                 input logic [NC-1:0] mask,
                                 input logic [CW-1:0] tmo,
                                 input logic [NC-1:0] eoc);
      bus.start_i   = st;
      bus.stop_i    = sp;
      bus.cl_mask_i = mask;
      bus.timeout_i = tmo;
      bus.cl_eoc_i  = eoc;
   endtask

   task automatic check_output(input string tag, input logic [31:0] obs,
                               input logic [31:0] exp);
      assert_count++;
      assert (obs === exp)
      else begin
         fail_count++;
         $error("[TB] FAIL %s (cycle %0d): observed 0x%0h, expected 0x%0h",
                tag, cyc, obs, exp);
      end
   endtask

   // Start pulse in cycle 0; mask/timeout inputs are cleared afterwards so
   // only the latched copies can steer the run.
   task automatic launch(input logic [NC-1:0] mask, input logic [CW-1:0] tmo);
      apply_stimulus(1'b1, 1'b0, mask, tmo, '0);
      cyc = 0;
      step();
      apply_stimulus(1'b0, 1'b0, '0, '0, '0);
   endtask

   initial begin
      rst = 1'b1;
      apply_stimulus(1'b0, 1'b0, '0, '0, '0);
      repeat (2) @(posedge clk);
      #1;
      check_output("rst_state",   32'(bus.state_o), 32'd0);
      check_output("rst_aux",     32'(bus.aux_rst_o), 32'd0);
      check_output("rst_fetch",   32'(bus.cl_fetch_en_o), 32'd0);
      check_output("rst_done",    32'(bus.done_o), 32'd0);
      check_output("rst_timeout", 32'(bus.timeout_o), 32'd0);
      check_output("rst_eoc",     32'(bus.eoc_seen_o), 32'd0);
      check_output("rst_cycles",  32'(bus.cycles_o), 32'd0);
      rst = 1'b0;
      step();

      // start with an empty mask must be ignored
      apply_stimulus(1'b1, 1'b0, '0, 8'd0, '0);
      step();
      apply_stimulus(1'b0, 1'b0, '0, '0, '0);
      check_output("zero_mask_state", 32'(bus.state_o), 32'd0);
      check_output("zero_mask_aux",   32'(bus.aux_rst_o), 32'd0);

      // boot, two clusters
      launch(4'b0011, 8'd0);
      check_output("boot_c1_state", 32'(bus.state_o), 32'd1);
      check_output("boot_c1_aux",   32'(bus.aux_rst_o), 32'd1);
      check_output("boot_c1_fetch", 32'(bus.cl_fetch_en_o), 32'd0);
      go_to(4);
      check_output("boot_c4_aux",   32'(bus.aux_rst_o), 32'd1);
      check_output("boot_c4_state", 32'(bus.state_o), 32'd1);
      go_to(5);
      check_output("boot_c5_aux",    32'(bus.aux_rst_o), 32'd0);
      check_output("boot_c5_fetch",  32'(bus.cl_fetch_en_o), 32'b0001);
      check_output("boot_c5_state",  32'(bus.state_o), 32'd2);
      check_output("boot_c5_cycles", 32'(bus.cycles_o), 32'd0);
      go_to(7);
      check_output("boot_c7_fetch",  32'(bus.cl_fetch_en_o), 32'b0001);
      check_output("boot_c7_cycles", 32'(bus.cycles_o), 32'd2);
      go_to(8);
      check_output("boot_c8_fetch",  32'(bus.cl_fetch_en_o), 32'b0011);
      check_output("boot_c8_state",  32'(bus.state_o), 32'd3);
      check_output("boot_c8_cycles", 32'(bus.cycles_o), 32'd3);
      go_to(10);
      apply_stimulus(1'b0, 1'b0, '0, '0, 4'b0001);
      step();
      apply_stimulus(1'b0, 1'b0, '0, '0, '0);
      check_output("boot_c11_eoc",   32'(bus.eoc_seen_o), 32'b0001);
      check_output("boot_c11_state", 32'(bus.state_o), 32'd3);
      go_to(12);
      apply_stimulus(1'b0, 1'b0, '0, '0, 4'b0010);
      step();
      apply_stimulus(1'b0, 1'b0, '0, '0, '0);
      check_output("boot_c13_state",   32'(bus.state_o), 32'd5);
      check_output("boot_c13_fetch",   32'(bus.cl_fetch_en_o), 32'd0);
      check_output("boot_c13_done",    32'(bus.done_o), 32'd1);
      check_output("boot_c13_eoc",     32'(bus.eoc_seen_o), 32'b0011);
      check_output("boot_c13_timeout", 32'(bus.timeout_o), 32'd0);
      check_output("boot_c13_aux",     32'(bus.aux_rst_o), 32'd0);
      apply_stimulus(1'b0, 1'b1, '0, '0, '0);
      step();
      apply_stimulus(1'b0, 1'b0, '0, '0, '0);
      check_output("done_stop_ignored", 32'(bus.state_o), 32'd5);

      // timeout of 10, with stop raised in the same cycle as the budget hit
      launch(4'b0011, 8'd10);
      check_output("tmo_c1_eoc",    32'(bus.eoc_seen_o), 32'd0);
      check_output("tmo_c1_cycles", 32'(bus.cycles_o), 32'd0);
      check_output("tmo_c1_done",   32'(bus.done_o), 32'd0);
      go_to(14);
      check_output("tmo_c14_state",  32'(bus.state_o), 32'd3);
      check_output("tmo_c14_cycles", 32'(bus.cycles_o), 32'd9);
      go_to(15);
      check_output("tmo_c15_cycles", 32'(bus.cycles_o), 32'd10);
      apply_stimulus(1'b0, 1'b1, '0, '0, '0);
      step();
      apply_stimulus(1'b0, 1'b0, '0, '0, '0);
      check_output("tmo_c16_state",   32'(bus.state_o), 32'd4);
      check_output("tmo_c16_fetch",   32'(bus.cl_fetch_en_o), 32'd0);
      check_output("tmo_c16_aux",     32'(bus.aux_rst_o), 32'd1);
      check_output("tmo_c16_timeout", 32'(bus.timeout_o), 32'd1);
      go_to(17);
      apply_stimulus(1'b0, 1'b0, '0, '0, 4'b0011);
      step();
      apply_stimulus(1'b0, 1'b0, '0, '0, '0);
      check_output("tmo_c18_eoc_frozen", 32'(bus.eoc_seen_o), 32'd0);
      go_to(19);
      check_output("tmo_c19_aux",   32'(bus.aux_rst_o), 32'd1);
      check_output("tmo_c19_state", 32'(bus.state_o), 32'd4);
      go_to(20);
      check_output("tmo_c20_state",   32'(bus.state_o), 32'd5);
      check_output("tmo_c20_aux",     32'(bus.aux_rst_o), 32'd0);
      check_output("tmo_c20_done",    32'(bus.done_o), 32'd1);
      check_output("tmo_c20_timeout", 32'(bus.timeout_o), 32'd1);

      // restart from DONE; completion coincides with a timeout of 5
      launch(4'b0011, 8'd5);
      check_output("rs_c1_timeout", 32'(bus.timeout_o), 32'd0);
      check_output("rs_c1_aux",     32'(bus.aux_rst_o), 32'd1);
      go_to(5);
      check_output("rs_c5_fetch", 32'(bus.cl_fetch_en_o), 32'b0001);
      go_to(6);
      apply_stimulus(1'b1, 1'b0, 4'b0100, 8'd0, '0);
      step();
      apply_stimulus(1'b0, 1'b0, '0, '0, '0);
      check_output("rs_start_ignored_state", 32'(bus.state_o), 32'd2);
      check_output("rs_start_ignored_fetch", 32'(bus.cl_fetch_en_o), 32'b0001);
      go_to(8);
      check_output("rs_c8_fetch", 32'(bus.cl_fetch_en_o), 32'b0011);
      check_output("rs_c8_state", 32'(bus.state_o), 32'd3);
      go_to(10);
      check_output("rs_c10_cycles", 32'(bus.cycles_o), 32'd5);
      apply_stimulus(1'b0, 1'b0, '0, '0, 4'b0011);
      step();
      apply_stimulus(1'b0, 1'b0, '0, '0, '0);
      check_output("rs_c11_state",   32'(bus.state_o), 32'd5);
      check_output("rs_c11_done",    32'(bus.done_o), 32'd1);
      check_output("rs_c11_timeout", 32'(bus.timeout_o), 32'd0);
      check_output("rs_c11_eoc",     32'(bus.eoc_seen_o), 32'b0011);

      // sparse mask 1010
      launch(4'b1010, 8'd0);
      go_to(5);
      check_output("sp_c5_fetch", 32'(bus.cl_fetch_en_o), 32'b0010);
      check_output("sp_c5_state", 32'(bus.state_o), 32'd2);
      go_to(6);
      apply_stimulus(1'b0, 1'b0, '0, '0, 4'b0101);
      step();
      apply_stimulus(1'b0, 1'b0, '0, '0, '0);
      check_output("sp_c7_eoc_unmasked", 32'(bus.eoc_seen_o), 32'd0);
      check_output("sp_c7_fetch",        32'(bus.cl_fetch_en_o), 32'b0010);
      go_to(8);
      check_output("sp_c8_fetch", 32'(bus.cl_fetch_en_o), 32'b1010);
      check_output("sp_c8_state", 32'(bus.state_o), 32'd3);
      go_to(9);
      apply_stimulus(1'b0, 1'b0, '0, '0, 4'b1010);
      step();
      apply_stimulus(1'b0, 1'b0, '0, '0, '0);
      check_output("sp_c10_state", 32'(bus.state_o), 32'd5);
      check_output("sp_c10_eoc",   32'(bus.eoc_seen_o), 32'b1010);
      check_output("sp_c10_fetch", 32'(bus.cl_fetch_en_o), 32'd0);

      // abort in ENABLE
      launch(4'b0011, 8'd0);
      go_to(6);
      check_output("ab_c6_state", 32'(bus.state_o), 32'd2);
      apply_stimulus(1'b0, 1'b1, '0, '0, '0);
      step();
      apply_stimulus(1'b0, 1'b0, '0, '0, '0);
      check_output("ab_c7_state", 32'(bus.state_o), 32'd4);
      check_output("ab_c7_fetch", 32'(bus.cl_fetch_en_o), 32'd0);
      check_output("ab_c7_aux",   32'(bus.aux_rst_o), 32'd1);
      go_to(10);
      check_output("ab_c10_aux", 32'(bus.aux_rst_o), 32'd1);
      go_to(11);
      check_output("ab_c11_state",   32'(bus.state_o), 32'd5);
      check_output("ab_c11_aux",     32'(bus.aux_rst_o), 32'd0);
      check_output("ab_c11_done",    32'(bus.done_o), 32'd1);
      check_output("ab_c11_timeout", 32'(bus.timeout_o), 32'd0);

      // single cluster goes straight to RUN; counter saturates at 255
      launch(4'b0001, 8'd0);
      go_to(5);
      check_output("sat_c5_state",  32'(bus.state_o), 32'd3);
      check_output("sat_c5_fetch",  32'(bus.cl_fetch_en_o), 32'b0001);
      check_output("sat_c5_cycles", 32'(bus.cycles_o), 32'd0);
      go_to(260);
      check_output("sat_c260_cycles", 32'(bus.cycles_o), 32'd255);
      go_to(270);
      check_output("sat_c270_cycles", 32'(bus.cycles_o), 32'd255);
      check_output("sat_c270_state",  32'(bus.state_o), 32'd3);

      // asynchronous reset mid-RUN, between clock edges
      #2;
      rst = 1'b1;
      #1;
      check_output("arst_state",  32'(bus.state_o), 32'd0);
      check_output("arst_aux",    32'(bus.aux_rst_o), 32'd0);
      check_output("arst_fetch",  32'(bus.cl_fetch_en_o), 32'd0);
      check_output("arst_cycles", 32'(bus.cycles_o), 32'd0);
      #2;
      rst = 1'b0;
      step();
      check_output("arst_after_state", 32'(bus.state_o), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures",
               assert_count, fail_count);
      $finish;
   end

endmodule

// File: doc/pspin_cluster_seq.md
# pspin_cluster_seq

Cluster boot/run sequencer for the PsPIN application. It sits between the host-facing control registers and the cluster array. On a start request it pulses the auxiliary reset, staggers per-cluster fetch enables, and watches end-of-computation with a cycle budget. It then parks in DONE with status for host readback.

## Interface
- NUM_CLUSTERS, 2, number of clusters sequenced
- RST_CYCLES, 16, aux reset pulse length in cycles (≥1)
- STAGGER_CYCLES, 8, cycles between consecutive fetch-enable rises (≥1)
- CNT_WIDTH, 32, width of cycle counter and timeout

- clk  in  1  clock
- rst  in  1  reset; asynchronous, active-high
- start_i  in  1  one-cycle start request
- stop_i  in  1  one-cycle abort request
- cl_mask_i  in  NUM_CLUSTERS  clusters to run; latched on accepted start
- timeout_i  in  CNT_WIDTH  run budget in cycles, 0 = disabled; latched on accepted start
- cl_eoc_i  in  NUM_CLUSTERS  per-cluster end of computation (level)
- aux_rst_o  out  1  cluster reset, high = held in reset
- cl_fetch_en_o  out  NUM_CLUSTERS  per-cluster fetch enable
- state_o  out  3  IDLE=0, RESET=1, ENABLE=2, RUN=3, STOP=4, DONE=5
- done_o  out  1  high in DONE
- timeout_o  out  1  sticky: last run ended by timeout
- eoc_seen_o  out  NUM_CLUSTERS  sticky OR of cl_eoc_i & latched mask
- cycles_o  out  CNT_WIDTH  cycles spent in ENABLE+RUN, saturating

## Operation
- All outputs are registered. Reset values: state IDLE, aux_rst_o=0, cl_fetch_en_o=0, done_o=0, timeout_o=0, eoc_seen_o=0, cycles_o=0, latched mask/timeout 0.
- IDLE/DONE: start_i with nonzero cl_mask_i is accepted. It latches mask and timeout, clears timeout_o, eoc_seen_o, cycles_o and fetch enables, and goes to RESET. start_i with zero mask is ignored. stop_i is ignored.
- RESET: aux_rst_o=1 for exactly RST_CYCLES cycles. On the exit edge aux_rst_o falls and the fetch bit of the lowest masked cluster rises. Next state is ENABLE, or RUN if that was the only masked cluster.
- ENABLE: every STAGGER_CYCLES cycles the fetch bit of the next higher masked cluster rises. Unmasked clusters are skipped with no delay (priority search). The edge raising the last masked bit enters RUN. Bits stay high once raised.
- RUN: waits until eoc_seen_o == latched mask, then goes to DONE. The exit edge clears all fetch bits.
- eoc_seen_o accumulates in ENABLE and RUN only.
- cycles_o resets to 0 on entry to ENABLE/RUN. It increments every cycle in ENABLE/RUN and saturates at all-ones.
- Timeout: in ENABLE/RUN, if the latched timeout is nonzero and cycles_o == timeout, the next edge goes to STOP and sets timeout_o.
- stop_i in RESET/ENABLE/RUN: the next edge goes to STOP (timeout_o unchanged).
- STOP: clears all fetch bits, holds aux_rst_o=1 for RST_CYCLES cycles, then goes to DONE with aux_rst_o=0.
- start_i and stop_i are ignored in STOP.
- Simultaneous events:
  - start_i and stop_i in IDLE/DONE: start wins.
  - start_i in active states: ignored.
  - Completion and timeout in the same RUN cycle: completion wins, timeout_o=0.
  - stop_i and timeout in the same cycle: STOP with timeout_o=1.
- cl_mask_i/timeout_i changes after acceptance have no effect until the next start.

## Timing
- Let start_i be sampled at edge E (cycle 0). aux_rst_o is high cycles 1..RST_CYCLES.
- The first masked fetch bit is high from cycle RST_CYCLES+1.
- The k-th masked bit (0-based) is high from cycle RST_CYCLES+1+k·STAGGER_CYCLES.
- cycles_o reads 0 in cycle RST_CYCLES+1, then increments by 1 per cycle.
- Completion: eoc sampled complete at edge N → DONE and fetch=0 from cycle N+1; one-cycle latency.
- Timeout/stop → STOP at the next edge. aux_rst_o is high for RST_CYCLES cycles, then DONE.
- Async rst mid-run: all outputs drop to reset values immediately and cluster fetch is removed. The first clk edge after rst deassertion is in IDLE.

## Test plan
- Boot, two clusters (RST_CYCLES=4, STAGGER_CYCLES=3, mask=2'b11, start at cycle 0):
  - aux_rst_o high cycles 1–4; fetch[0] from 5; fetch[1] and state_o=3 from 8.
  - eoc[0] at 10, eoc[1] at 12 → eoc_seen_o=2'b11; DONE and fetch=0 from 13; done_o=1; timeout_o=0.
- Sparse mask (NUM_CLUSTERS=4, mask=4'b1010): fetch[1] from cycle 5, fetch[3] from 8; bits 0 and 2 never rise; eoc on unmasked clusters ignored.
- Timeout (timeout_i=10, no eoc): cycles_o=10 at cycle 15; STOP at 16 with fetch=0, aux_rst_o high 16–19; DONE at 20 with timeout_o=1.
- Abort and precedence:
  - stop_i in cycle 6 → STOP at 7, aux_rst_o high 7–10, DONE at 11, timeout_o=0.
  - start_i in ENABLE is ignored; start_i with mask 0 in IDLE is ignored.
- Restart from DONE: start_i clears timeout_o, eoc_seen_o and cycles_o and repeats the scenario-1 timing exactly.
- Async rst asserted mid-RUN without a clk edge: aux_rst_o=0, fetch=0 and state_o=0 immediately.
